// File: rtl/spi_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : spi_frame_sequencer
// Purpose : Decodes SPI cmd/addr/data frames into register-bank strobes and
//           loads read-burst responses; optional SPI_SEQ_TIMEOUT_EN aborts
//           frames after TIMEOUT_CYC idle cycles between bytes.
// Rev     : 1.0
// ============================================================================
module spi_frame_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 25000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              frame_end,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err,
    output logic [7:0]        frame_cnt,
    output logic              busy
);

    localparam logic [7:0] C_OP_WRITE = 8'h01;
    localparam logic [7:0] C_OP_READ  = 8'h02;

    typedef enum logic [2:0] {
        S_CMD     = 3'd0,
        S_ADDR    = 3'd1,
        S_WR      = 3'd2,
        S_RD      = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic                data_seen_q, data_seen_d;
    logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic                reg_we_q, reg_we_d;
    logic                reg_re_q, reg_re_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_q;
    logic             w_tmo_hit;

    assign w_tmo_hit = (state_q != S_CMD) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (rx_valid || (state_q == S_CMD) || w_tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CMD;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            rd_pend_q   <= 1'b0;
            data_seen_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            tx_byte_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            addr_q      <= addr_d;
            rd_pend_q   <= rd_pend_d;
            data_seen_q <= data_seen_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            tx_byte_q   <= tx_byte_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        data_seen_d = data_seen_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;
        // Read data arrives the cycle after reg_re; that cycle is the tx_load slot.
        rd_pend_d   = reg_re_q;
        tx_byte_d   = rd_pend_q ? reg_rdata : tx_byte_q;

        if (rx_valid) begin
            case (state_q)
                S_CMD: begin
                    if ((rx_byte == C_OP_WRITE) || (rx_byte == C_OP_READ)) begin
                        op_wr_d     = (rx_byte == C_OP_WRITE);
                        err_d       = 1'b0;
                        data_seen_d = 1'b0;
                        state_d     = S_ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end
                end
                S_ADDR: begin
                    addr_d = rx_byte[ADDR_W-1:0];
                    if (op_wr_q) begin
                        state_d = S_WR;
                    end else begin
                        reg_re_d   = 1'b1;
                        reg_addr_d = rx_byte[ADDR_W-1:0];
                        state_d    = S_RD;
                    end
                end
                S_WR: begin
                    reg_we_d    = 1'b1;
                    reg_addr_d  = addr_q;
                    reg_wdata_d = rx_byte;
                    addr_d      = addr_q + ADDR_W'(1);
                    data_seen_d = 1'b1;
                end
                S_RD: begin
                    reg_re_d    = 1'b1;
                    reg_addr_d  = addr_q + ADDR_W'(1);
                    addr_d      = addr_q + ADDR_W'(1);
                    data_seen_d = 1'b1;
                end
                default: begin
                end
            endcase
        end

`ifdef SPI_SEQ_TIMEOUT_EN
        if (w_tmo_hit && !rx_valid && !frame_end) begin
            state_d     = S_CMD;
            err_d       = 1'b1;
            rd_pend_d   = 1'b0;
            data_seen_d = 1'b0;
        end
`endif

        // Frame close is judged on the state after any coincident byte.
        if (frame_end) begin
            if (((state_d == S_WR) || (state_d == S_RD)) && data_seen_d && !err_d) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (state_d == S_ADDR) begin
                err_d = 1'b1;
            end
            state_d     = S_CMD;
            reg_re_d    = 1'b0;
            rd_pend_d   = 1'b0;
            data_seen_d = 1'b0;
        end
    end

    assign tx_byte   = rd_pend_q ? reg_rdata : tx_byte_q;
    assign tx_load   = rd_pend_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;
    assign busy      = (state_q != S_CMD);

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_frame_sequencer
// Purpose : Self-checking bench: frame table plus hand-written corner cases,
//           with a scoreboard for register writes and transmit loads.
// Rev     : 1.0
// ============================================================================
module tb_spi_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_end;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_err;
    logic [7:0] frame_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic [15:0] we_q [$];
    logic [7:0]  tx_q [$];
    logic        prev_re;
    int          exp_cnt;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          cnt_inc;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    spi_frame_sequencer #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_end (frame_end),
        .tx_byte   (tx_byte),
        .tx_load   (tx_load),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #20 clk = ~clk;

    // Register bank: read data is valid the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
        if (reg_we) mem[reg_addr] <= reg_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_re = 1'b0;
        end else begin
            if (reg_we) begin
                if (we_q.size() == 0) begin
                    chk("unexpected reg_we", {reg_addr, reg_wdata}, 64'hDEAD);
                end else begin
                    logic [15:0] e;
                    e = we_q.pop_front();
                    chk("reg_we addr/data", {reg_addr, reg_wdata}, e);
                end
            end
            if (tx_load) begin
                chk("reg_re->tx_load latency", prev_re, 1);
                if (tx_q.size() == 0) begin
                    chk("unexpected tx_load", tx_byte, 64'hDEAD);
                end else begin
                    logic [7:0] t;
                    t = tx_q.pop_front();
                    chk("tx_byte", tx_byte, t);
                end
            end
            if (reg_we && reg_re) chk("reg_we with reg_re", 1, 0);
            prev_re = reg_re;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit fe, input int gap);
        @(posedge clk); #1;
        rx_byte   = b;
        rx_valid  = 1'b1;
        frame_end = fe;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op, ad, b;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i ^ 8'h5A);
            exp_mem[i] = 8'(i ^ 8'h5A);
        end
        mem[8'h20] = 8'h3C; exp_mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3; exp_mem[8'h21] = 8'hC3;
        mem[8'h22] = 8'h77; exp_mem[8'h22] = 8'h77;

        vecs[0] = '{32'h0110A55A, 4, 1, 1'b0};
        vecs[1] = '{32'h02200000, 4, 1, 1'b0};
        vecs[2] = '{32'h01FF1122, 4, 1, 1'b0};
        vecs[3] = '{32'h7E010000, 3, 0, 1'b1};
        vecs[4] = '{32'h01406600, 3, 1, 1'b0};
        vecs[5] = '{32'h02000000, 1, 0, 1'b1};
        vecs[6] = '{32'h00000000, 0, 0, 1'b1};
        vecs[7] = '{32'h02100000, 3, 1, 1'b0};
        vecs[8] = '{32'h01050000, 2, 0, 1'b0};

        rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; frame_end = 1'b0;
        reg_rdata = '0; exp_cnt = 0; prev_re = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs",
            {tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, frame_err, frame_cnt, busy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++) begin
            op = vecs[v].bytes[31:24];
            ad = vecs[v].bytes[23:16];
            for (int i = 0; i < vecs[v].n; i++) begin
                b = vecs[v].bytes[31-8*i -: 8];
                if (i == 1 && op == 8'h02) tx_q.push_back(exp_mem[ad]);
                if (i >= 2 && op == 8'h01) begin
                    we_q.push_back({ad, b});
                    exp_mem[ad] = b;
                    ad = ad + 8'd1;
                end else if (i >= 2 && op == 8'h02) begin
                    ad = ad + 8'd1;
                    tx_q.push_back(exp_mem[ad]);
                end
                send_byte(b, 1'b0, 3);
            end
            end_frame();
            exp_cnt += vecs[v].cnt_inc;
            chk($sformatf("vec%0d frame_cnt", v), frame_cnt, 8'(exp_cnt));
            chk($sformatf("vec%0d frame_err", v), frame_err, vecs[v].err);
            chk($sformatf("vec%0d busy", v), busy, 0);
        end

        // Byte coincident with frame_end in the write state.
        send_byte(8'h01, 1'b0, 3);
        send_byte(8'h05, 1'b0, 3);
        we_q.push_back(16'h0599);
        send_byte(8'h99, 1'b1, 0);
        @(negedge clk);
        chk("coincident busy", busy, 0);
        repeat (2) @(negedge clk);
        exp_cnt++;
        chk("coincident frame_cnt", frame_cnt, 8'(exp_cnt));
        chk("coincident frame_err", frame_err, 0);

        // frame_end while the first read is in flight: no tx_load.
        send_byte(8'h02, 1'b0, 3);
        send_byte(8'h20, 1'b0, 0);
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("dropped read frame_cnt", frame_cnt, 8'(exp_cnt));
        chk("dropped read busy", busy, 0);

        // Stall after the address byte.
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h30, 1'b0, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
`ifdef SPI_SEQ_TIMEOUT_EN
        chk("timeout frame_err", frame_err, 1);
        chk("timeout busy", busy, 0);
        chk("timeout frame_cnt", frame_cnt, 8'(exp_cnt));
`else
        chk("stall busy", busy, 1);
        chk("stall frame_err", frame_err, 0);
`endif
        end_frame();
        chk("stall frame_cnt", frame_cnt, 8'(exp_cnt));

        // Reset asserted while a read strobe is pending.
        send_byte(8'h02, 1'b0, 3);
        send_byte(8'h30, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid-read reset outputs",
            {tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, frame_err, frame_cnt, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        repeat (4) @(posedge clk);

        send_byte(8'h01, 1'b0, 3);
        send_byte(8'h80, 1'b0, 3);
        we_q.push_back(16'h8012);
        send_byte(8'h12, 1'b0, 3);
        end_frame();
        exp_cnt++;
        chk("post-reset frame_cnt", frame_cnt, 8'(exp_cnt));
        chk("post-reset frame_err", frame_err, 0);

        chk("write queue drained", we_q.size(), 0);
        chk("tx queue drained", tx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_frame_sequencer.md
Name: spi_frame_sequencer

Overview:
- Protocol controller behind the SPI slave byte engine; runs on the same 25 MHz system clock.
- Consumes the received byte stream and end-of-frame strobe, decodes frames of the form command, address, data..., and drives an on-chip register bank through a single-port read/write strobe interface.
- Loads response bytes into the slave's transmit holding register for read bursts.
- Reports frame errors and a completed-frame count for debug LEDs.

Parameters:
- ADDR_W, 8, register address width; address auto-increments and wraps modulo 2^ADDR_W.
- DATA_W, 8, register data width; fixed equal to the SPI byte width.
- TIMEOUT_CYC, 25000, idle cycles between bytes before a frame is aborted (used only with the optional feature).

Ports:
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  byte from the SPI slave; valid when rx_valid=1.
- rx_valid  in  1  one-cycle pulse per received byte (byte_received).
- frame_end  in  1  one-cycle pulse when slave select deasserts (data_transaction_complete).
- tx_byte  out  8  next byte for MISO.
- tx_load  out  1  one-cycle pulse; the slave latches tx_byte for the next byte slot.
- reg_addr  out  ADDR_W  register bank address.
- reg_wdata  out  DATA_W  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  read data, valid exactly 1 cycle after reg_re.
- frame_err  out  1  sticky error flag; cleared by the next valid command byte.
- frame_cnt  out  8  completed good frames; wraps 255 to 0.
- busy  out  1  high whenever state is not S_CMD.

Behaviour:
- Reset: all outputs 0. State is S_CMD. Internal address and read-pending flag are 0.
- Opcodes:
  - 0x01 is WRITE.
  - 0x02 is READ.
  - Any other byte is illegal.
- S_CMD, on rx_valid:
  - 0x01 or 0x02 stores the opcode, clears frame_err, and goes to S_ADDR.
  - An illegal byte sets frame_err and goes to S_DISCARD.
- S_ADDR, on rx_valid:
  - Latch addr = rx_byte[ADDR_W-1:0].
  - WRITE goes to S_WR.
  - READ pulses reg_re with reg_addr=addr in the next cycle and goes to S_RD.
- S_WR, per rx_valid: reg_we pulses 1 cycle later with reg_wdata=rx_byte and reg_addr=addr, then addr increments.
- S_RD:
  - tx_byte <= reg_rdata and tx_load pulses exactly 1 cycle after each reg_re, so reg_re to tx_load latency is 1 cycle.
  - Each rx_valid (dummy byte) increments addr and issues reg_re at the new address.
  - Byte 0 of the response is the pre-loaded value; the master receives reg[addr] during the third byte slot.
- S_DISCARD: ignores bytes until frame_end.
- frame_end, any state:
  - Returns to S_CMD on the following cycle and drops any in-flight read (no tx_load).
  - frame_cnt increments only if leaving S_WR or S_RD with at least one data byte handled and frame_err=0.
  - A frame ending in S_CMD or S_ADDR is short. A short frame sets frame_err only if a command byte was received; an empty frame (no bytes) is a no-op.
- rx_valid and frame_end in the same cycle: the byte is processed first (including its reg_we), then the frame closes.
- Address wrap: 0xFF + 1 gives 0x00, with no error.
- reg_we and reg_re are never asserted in the same cycle.
- Reset mid-frame: immediate return to the reset state; a pending strobe is not issued.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_valid and on entry to S_CMD.
  - While busy=1 it increments each cycle.
  - On reaching TIMEOUT_CYC-1 it sets frame_err, returns to S_CMD, and does not increment frame_cnt.
  - Later bytes of that frame are treated as a new frame's command byte.
- Undefined: no counter exists; a frame without frame_end waits in its state indefinitely.

Test Plan:
- Bytes 0x01,0x10,0xA5,0x5A then frame_end -> reg_we at addr 0x10 data 0xA5, then 0x11 data 0x5A; frame_cnt=1, frame_err=0.
- Register bank preloaded with reg[0x20]=0x3C and reg[0x21]=0xC3; bytes 0x02,0x20,0x00,0x00 -> tx_load carries 0x3C after the address byte, then 0xC3; each tx_load is exactly 1 cycle after reg_re.
- Bytes 0x01,0xFF,0x11,0x22 -> writes to 0xFF then 0x00 (wrap); frame_err=0.
- Bytes 0x7E,0x01,0x00 then frame_end -> frame_err=1, no reg_we, frame_cnt unchanged; next frame 0x01,... clears frame_err.
- rx_valid with 0x99 coincident with frame_end in S_WR at addr 0x05 -> reg_we at 0x05 with 0x99, state S_CMD, frame_cnt increments; separately, rst_n asserted mid-read -> no tx_load, all outputs 0.
- With SPI_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: bytes 0x01,0x30 then a 20-cycle stall -> frame_err=1 at cycle 16, busy=0, frame_cnt unchanged.
